// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and entry layout for the write-back queue.
package wb_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;

    // One pending register-file write as it sits in the queue.
    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order storage for pending writes. It holds the entry array,
// the head and tail pointers and the occupancy count. The full entry array
// is exported so that the parent can run its bypass search over it.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = REG_IDX_W + XLEN
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 wdata,
    output logic [DEPTH-1:0][W-1:0]      entries,
    output logic [$clog2(DEPTH)-1:0]     head,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] tail;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == (PTR_W+1)'(0));

    // Entry storage: write the new result at the tail slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries <= '0;
        end else if (push) begin
            entries[tail] <= wdata;
        end else begin
            entries <= entries;
        end
    end

    // Pointers wrap naturally at DEPTH; the count tracks push minus pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end else begin
                tail <= tail;
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end else begin
                head <= head;
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_queue.sv
// wb_queue: write-back queue and sole writer of the register file.
// Results are accepted through a valid/ready handshake, buffered in order
// and retired one per cycle onto the registered write port. Writes to x0
// complete the handshake but are dropped.
// Optional feature macro: WB_FWD_EN compiles in the bypass lookup; when it
// is undefined the rs*_hit / rs*_fwd_data outputs are tied to zero.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = wb_pkg::XLEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rd,
    input  logic [XLEN-1:0]      in_data,
    output logic                 wb_en,
    output logic [4:0]           rd_index,
    output logic [XLEN-1:0]      wb_data,
    input  logic [4:0]           rs1_index,
    input  logic [4:0]           rs2_index,
    output logic                 rs1_hit,
    output logic                 rs2_hit,
    output logic [XLEN-1:0]      rs1_fwd_data,
    output logic [XLEN-1:0]      rs2_fwd_data
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = REG_IDX_W + XLEN;

    logic [DEPTH-1:0][ENTRY_W-1:0] entries_s;
    logic [PTR_W-1:0]              head_s;
    logic [PTR_W:0]                count_s;
    logic                          full_s;
    logic                          empty_s;
    logic                          push_s;
    logic                          pop_s;
    logic [ENTRY_W-1:0]            head_entry_s;

    // A handshake with rd == 0 is consumed without being stored.
    assign in_ready     = !full_s;
    assign push_s       = in_valid && in_ready && (in_rd != 5'd0);
    assign pop_s        = !empty_s;
    assign head_entry_s = entries_s[head_s];

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_s),
        .pop     (pop_s),
        .wdata   ({in_rd, in_data}),
        .entries (entries_s),
        .head    (head_s),
        .count   (count_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Register-file write port: retire the head whenever the queue is not
    // empty; index and data hold their last value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en    <= 1'b0;
            rd_index <= 5'd0;
            wb_data  <= '0;
        end else if (pop_s) begin
            wb_en    <= 1'b1;
            rd_index <= head_entry_s[ENTRY_W-1 -: REG_IDX_W];
            wb_data  <= head_entry_s[XLEN-1:0];
        end else begin
            wb_en    <= 1'b0;
            rd_index <= rd_index;
            wb_data  <= wb_data;
        end
    end

`ifdef WB_FWD_EN
    // Bypass search for one index. The output register is the oldest
    // candidate, then queue slots from head (oldest) to tail (youngest);
    // later matches overwrite earlier ones so the youngest value wins.
    function automatic logic [XLEN:0] lookup(
        input logic [4:0]                    idx,
        input logic [DEPTH-1:0][ENTRY_W-1:0] ents,
        input logic [PTR_W-1:0]              hd,
        input logic [PTR_W:0]                cnt,
        input logic                          out_en,
        input logic [4:0]                    out_rd,
        input logic [XLEN-1:0]               out_data
    );
        logic [XLEN:0]    res;
        logic [PTR_W-1:0] slot;
        res  = '0;
        slot = '0;
        if (idx != 5'd0) begin
            if (out_en && (out_rd == idx)) begin
                res = {1'b1, out_data};
            end else begin
                res = '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                slot = hd + PTR_W'(i);
                if (((PTR_W+1)'(i) < cnt) &&
                    (ents[slot][ENTRY_W-1 -: REG_IDX_W] == idx)) begin
                    res = {1'b1, ents[slot][XLEN-1:0]};
                end else begin
                    res = res;
                end
            end
        end else begin
            res = '0;
        end
        return res;
    endfunction

    // Bypass outputs for both read ports.
    always_comb begin
        {rs1_hit, rs1_fwd_data} = lookup(rs1_index, entries_s, head_s, count_s,
                                         wb_en, rd_index, wb_data);
        {rs2_hit, rs2_fwd_data} = lookup(rs2_index, entries_s, head_s, count_s,
                                         wb_en, rd_index, wb_data);
    end
`else
    logic unused_fwd_s;

    assign unused_fwd_s = ^{rs1_index, rs2_index, count_s};

    // Bypass compiled out: the lookup outputs are constant zero.
    always_comb begin
        rs1_hit      = 1'b0;
        rs2_hit      = 1'b0;
        rs1_fwd_data = '0;
        rs2_fwd_data = '0;
    end
`endif

endmodule
